run_sequencer: RTL and testbench
================================

// Module: run_sequencer
// PURPOSE
//  Parametrised program sequencer for the 9-bit-ISA CPU. Owns the program counter,
//  the req/done run handshake, a writable branch-target LUT, relative branches,
//  halt detection and a cycle counter. Datapath blocks sit alongside it.
//  Replaces the fixed PC + read-only LUT + hardwired "done at PC==128" scheme.
// PARAMETERS
//  D          12    program counter width
//  L          5     LUT index width (2**L target entries)
//  C          16    cycle counter width
//  START_ADDR 0     PC loaded when a run starts
//  END_ADDR   128   PC value that ends a run (no halt instruction needed)
//  WDOG_LIMIT 4000  cycle count that forces a timeout (watchdog build only)
// PORTS
//  clk          in   1  clock
//  reset        in   1  asynchronous, active-high reset
//  req          in   1  start request, sampled at the clock edge
//  done         out  1  run finished; held until the next accepted req
//  busy         out  1  state == RUN
//  run_en       out  1  busy & ~stall; datapath ANDs this into RegWrite/MemWrite
//  prog_ctr     out  D  current instruction address
//  branch_en    in   1  absolute branch taken (condition already resolved)
//  lut_idx      in   L  LUT entry that holds the absolute target
//  rel_en       in   1  relative branch taken
//  rel_off      in   8  signed offset, two's complement, relative to prog_ctr
//  halt_instr   in   1  current instruction is HALT
//  stall        in   1  freeze PC and counter for this cycle
//  lut_wr_en    in   1  LUT write strobe
//  lut_wr_addr  in   L  LUT write index
//  lut_wr_data  in   D  LUT write data
//  cycle_cnt    out  C  RUN cycles in the current or last run
//  timeout      out  1  last run ended by the watchdog
// BEHAVIOUR
//  Reset (async): state=IDLE, prog_ctr=START_ADDR, done=0, busy=0, cycle_cnt=0,
//   timeout=0. LUT contents are not reset; entries are undefined until written.
//  FSM: IDLE --req--> RUN; RUN --end condition--> DONE; DONE --req--> RUN.
//   A req in RUN is ignored.
//  Entering RUN: prog_ctr=START_ADDR, cycle_cnt=0, timeout=0, done=0.
//   First fetch occurs in the cycle after the req edge.
//  In RUN, when stall=1: nothing changes.
//  In RUN, when stall=0, next PC priority is:
//   1. halt_instr               -> DONE
//   2. branch_en                -> lut[lut_idx]
//   3. rel_en                   -> prog_ctr + sext(rel_off), D-bit modulo wrap
//   4. otherwise                -> prog_ctr + 1
//  End conditions:
//   - Halt: prog_ctr holds the halt address.
//   - If the computed next PC == END_ADDR: go to DONE, and prog_ctr takes END_ADDR.
//  cycle_cnt increments on every non-stalled RUN cycle, including the final one.
//   It saturates at all-ones. It is held in IDLE and DONE.
//  LUT writes take effect only in IDLE or DONE; writes in RUN are dropped.
//   Reads are combinational. A write and a read of the same entry in the same
//   cycle returns the old value.
//  done is registered: it asserts the cycle after the end condition and drops
//   the cycle after an accepted req.
//  Reset mid-run: immediate return to IDLE. No done pulse is produced.
// CONFIGURATION
//  RUN_SEQUENCER_WATCHDOG_EN defined:
//   - cycle_cnt == WDOG_LIMIT in RUN forces DONE with timeout=1.
//   - A halt in the same cycle takes precedence: timeout stays 0.
//  Macro undefined: timeout is tied 0; WDOG_LIMIT is unused.
// STRUCTURE
//  cpu_pkg: seq_state_t enum {IDLE, RUN, DONE} plus default D/L/C localparams,
//   shared with control and top level.
//  Sub-module branch_lut: 2**L x D register array with one write port and one
//   combinational read port; it replaces the fixed LUT.
// TESTING
//  1. Reset, req=1 for 1 cycle, no branches: PC steps 0..127; done=1 the cycle
//     after PC reaches 128; cycle_cnt=128.
//  2. lut[3]=40 written in IDLE; at PC=5 pulse branch_en, lut_idx=3: next PC=40.
//     Assert a write to lut[3] during RUN: it is ignored.
//  3. At PC=20: rel_off=-4 gives next PC 16; rel_off=+7 gives 27.
//     branch_en with rel_en together: absolute target wins.
//  4. stall=1 for 3 cycles at PC=10: PC, cycle_cnt and run_en=0 hold; resume at 11.
//  5. halt_instr at PC=9: done next cycle, prog_ctr=9. req again: PC restarts at 0.
//     Assert reset mid-run: IDLE with all outputs zero.
//  6. Watchdog build, WDOG_LIMIT=50, branch loop lut[0]=0: DONE with timeout=1
//     and cycle_cnt=50. Non-watchdog build: timeout stays 0.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared types and default widths for the program sequencer and its neighbours.
package run_sequencer_pkg;

  localparam int unsigned SEQ_D = 12;  // program counter width
  localparam int unsigned SEQ_L = 5;   // branch LUT index width
  localparam int unsigned SEQ_C = 16;  // cycle counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Run handshake, branch controls and LUT write port between the CPU control
// (master) and the program sequencer (slave).
interface run_sequencer_if
  import run_sequencer_pkg::*;
#(
  parameter int unsigned D = SEQ_D,
  parameter int unsigned L = SEQ_L,
  parameter int unsigned C = SEQ_C
) ();

  logic         req;
  logic         done;
  logic         busy;
  logic         run_en;
  logic [D-1:0] prog_ctr;
  logic         branch_en;
  logic [L-1:0] lut_idx;
  logic         rel_en;
  logic [7:0]   rel_off;
  logic         halt_instr;
  logic         stall;
  logic         lut_wr_en;
  logic [L-1:0] lut_wr_addr;
  logic [D-1:0] lut_wr_data;
  logic [C-1:0] cycle_cnt;
  logic         timeout;

  modport master (
    output req, branch_en, lut_idx, rel_en, rel_off, halt_instr, stall,
           lut_wr_en, lut_wr_addr, lut_wr_data,
    input  done, busy, run_en, prog_ctr, cycle_cnt, timeout
  );

  modport slave (
    input  req, branch_en, lut_idx, rel_en, rel_off, halt_instr, stall,
           lut_wr_en, lut_wr_addr, lut_wr_data,
    output done, busy, run_en, prog_ctr, cycle_cnt, timeout
  );

endinterface

// File: rtl/run_sequencer_branch_lut.sv
// Writable branch-target table: 2**L entries of D bits, one synchronous write
// port and one combinational read port. Entries are not reset; a same-cycle
// write and read of one entry returns the old contents.
module branch_lut #(
  parameter int unsigned D = 12,
  parameter int unsigned L = 5
) (
  input  logic         clk,
  input  logic         wr_en_i,
  input  logic [L-1:0] wr_addr_i,
  input  logic [D-1:0] wr_data_i,
  input  logic [L-1:0] rd_addr_i,
  output logic [D-1:0] rd_data_o
);

  logic [D-1:0] mem_q [2**L];

  // table write; gating against RUN is done by the owner
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/run_sequencer.sv
// Program sequencer: owns the PC, the req/done run handshake, branch target
// LUT, relative branches, halt / end-address detection and a cycle counter.
// Optional watchdog: define RUN_SEQUENCER_WATCHDOG_EN to end a run with
// timeout=1 once cycle_cnt reaches WDOG_LIMIT.
//
// state | meaning
// IDLE  | out of reset, waiting for req
// RUN   | fetching; PC advances on every non-stalled cycle
// DONE  | run ended, done held until the next accepted req
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned D          = SEQ_D,
  parameter int unsigned L          = SEQ_L,
  parameter int unsigned C          = SEQ_C,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 128
`ifdef RUN_SEQUENCER_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_LIMIT = 4000
`endif
) (
  input logic          clk,
  input logic          reset,
  run_sequencer_if.slave bus
);

  seq_state_t   state_q;
  logic [D-1:0] pc_q, pc_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic         done_q;
  logic         timeout_q;
  logic         wdog_hit;
  logic [D-1:0] lut_target;

  branch_lut #(.D(D), .L(L)) u_lut (
    .clk       (clk),
    .wr_en_i   (bus.lut_wr_en && (state_q != RUN)),
    .wr_addr_i (bus.lut_wr_addr),
    .wr_data_i (bus.lut_wr_data),
    .rd_addr_i (bus.lut_idx),
    .rd_data_o (lut_target)
  );

  // next PC by branch priority, and saturating next count
  always_comb begin
    pc_d = pc_q + D'(1);
    if (bus.branch_en)   pc_d = lut_target;
    else if (bus.rel_en) pc_d = pc_q + {{(D-8){bus.rel_off[7]}}, bus.rel_off};
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + C'(1);
  end

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  assign wdog_hit = (cnt_d == C'(WDOG_LIMIT));
`else
  assign wdog_hit = 1'b0;
`endif

  // run FSM with registered PC, counter, done and timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= D'(START_ADDR);
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.req) begin
            state_q   <= RUN;
            pc_q      <= D'(START_ADDR);
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            cnt_q <= cnt_d;
            if (bus.halt_instr) begin
              // PC stays on the halt instruction
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (wdog_hit) begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
              end else if (pc_d == D'(END_ADDR)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.run_en    = (state_q == RUN) && !bus.stall;
  assign bus.cycle_cnt = cnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed vector table, hand sequences for the
// multi-cycle cases, then random stimulus against an integer reference model.
module tb_run_sequencer;
  import run_sequencer_pkg::*;

  localparam int D     = 12;
  localparam int L     = 5;
  localparam int C     = 16;
  localparam int START = 0;
  localparam int ENDA  = 128;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam int WDOG  = 50;
`endif

  logic clk = 1'b0;
  logic reset;

  run_sequencer_if #(.D(D), .L(L), .C(C)) bus ();

  run_sequencer #(
    .D(D), .L(L), .C(C), .START_ADDR(START), .END_ADDR(ENDA)
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    , .WDOG_LIMIT(WDOG)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit m_run, m_done, m_to;
  int m_pc, m_cnt;
  int m_lut [32];

  typedef struct {
    bit req; bit stall; bit br; int idx; bit rel; int off; bit halt;
    bit we; int wa; int wd;
    int e_pc; bit e_done; bit e_busy; int e_cnt;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input bit req, input bit stall, input bit br, input int idx,
                       input bit rel, input int off, input bit halt,
                       input bit we, input int wa, input int wd);
    logic [31:0] o, ix, a, dd;
    o = off; ix = idx; a = wa; dd = wd;
    bus.req         = req;
    bus.stall       = stall;
    bus.branch_en   = br;
    bus.lut_idx     = ix[L-1:0];
    bus.rel_en      = rel;
    bus.rel_off     = o[7:0];
    bus.halt_instr  = halt;
    bus.lut_wr_en   = we;
    bus.lut_wr_addr = a[L-1:0];
    bus.lut_wr_data = dd[D-1:0];
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_to = 0; m_pc = START; m_cnt = 0;
  endtask

  // one clock of the behavioural rules, using the inputs present at the edge
  task automatic model_step();
    int nxt, o;
    bit wd_hit;
    if (!m_run) begin
      if (bus.lut_wr_en) m_lut[int'(bus.lut_wr_addr)] = int'(bus.lut_wr_data);
      if (bus.req) begin
        m_run = 1; m_pc = START; m_cnt = 0; m_to = 0; m_done = 0;
      end
    end else if (!bus.stall) begin
      if (m_cnt < (1 << C) - 1) m_cnt = m_cnt + 1;
      wd_hit = 0;
`ifdef RUN_SEQUENCER_WATCHDOG_EN
      wd_hit = (m_cnt == WDOG);
`endif
      if (bus.halt_instr) begin
        m_run = 0; m_done = 1;
      end else begin
        o = int'($signed(bus.rel_off));
        if (bus.branch_en)   nxt = m_lut[int'(bus.lut_idx)];
        else if (bus.rel_en) nxt = (((m_pc + o) % (1 << D)) + (1 << D)) % (1 << D);
        else                 nxt = (m_pc + 1) % (1 << D);
        m_pc = nxt;
        if (wd_hit) begin
          m_run = 0; m_done = 1; m_to = 1;
        end else if (nxt == ENDA) begin
          m_run = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},      bus.prog_ctr,  m_pc);
    chk({tag, ".done"},    bus.done,      m_done);
    chk({tag, ".busy"},    bus.busy,      m_run);
    chk({tag, ".run_en"},  bus.run_en,    m_run && !bus.stall);
    chk({tag, ".cnt"},     bus.cycle_cnt, m_cnt);
    chk({tag, ".timeout"}, bus.timeout,   m_to);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          req st br idx rel off halt we wa wd    pc  dn by cnt
    tv[0]  = '{0, 0, 0, 0, 0,  0, 0, 1, 3, 40,     0, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0,  0, 0, 1, 7, 100,    0, 0, 0, 0};
    tv[2]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 0, 1, 0};
    tv[3]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      1, 0, 1, 1};
    tv[4]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      2, 0, 1, 2};
    tv[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      3, 0, 1, 3};
    tv[6]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      4, 0, 1, 4};
    tv[7]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,      5, 0, 1, 5};
    tv[8]  = '{0, 0, 1, 3, 0,  0, 0, 1, 3, 99,     40, 0, 1, 6};
    tv[9]  = '{0, 0, 0, 0, 1, -4, 0, 0, 0, 0,      36, 0, 1, 7};
    tv[10] = '{0, 0, 0, 0, 1,  7, 0, 0, 0, 0,      43, 0, 1, 8};
    tv[11] = '{0, 0, 1, 3, 1,  7, 0, 0, 0, 0,      40, 0, 1, 9};
    tv[12] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0,      40, 0, 1, 9};
    tv[13] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0,      40, 0, 1, 9};
    tv[14] = '{0, 1, 0, 0, 0,  0, 1, 0, 0, 0,      40, 0, 1, 9};
    tv[15] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0,      40, 1, 0, 10};
    tv[16] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0,      0, 0, 1, 0};
    tv[17] = '{0, 0, 1, 7, 0,  0, 0, 0, 0, 0,      100, 0, 1, 1};
    tv[18] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,      101, 0, 1, 2};

    // reset state
    do_reset();
    chk("rst.pc", bus.prog_ctr, START);
    chk("rst.done", bus.done, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.run_en", bus.run_en, 0);
    chk("rst.cnt", bus.cycle_cnt, 0);
    chk("rst.timeout", bus.timeout, 0);

    // directed vector table: LUT branch, dropped RUN write, relative branches,
    // branch-over-relative priority, stall, halt, restart
    for (int i = 0; i < 19; i++) begin
      drive(tv[i].req, tv[i].stall, tv[i].br, tv[i].idx, tv[i].rel, tv[i].off,
            tv[i].halt, tv[i].we, tv[i].wa, tv[i].wd);
      tick();
      chk($sformatf("vec%0d.pc", i), bus.prog_ctr, tv[i].e_pc);
      chk($sformatf("vec%0d.done", i), bus.done, tv[i].e_done);
      chk($sformatf("vec%0d.busy", i), bus.busy, tv[i].e_busy);
      chk($sformatf("vec%0d.run_en", i), bus.run_en, tv[i].e_busy && !tv[i].stall);
      chk($sformatf("vec%0d.cnt", i), bus.cycle_cnt, tv[i].e_cnt);
    end

`ifndef RUN_SEQUENCER_WATCHDOG_EN
    // full run to the end address
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_idle();
    chk("run.first_pc", bus.prog_ctr, 0);
    for (int k = 1; k < 128; k++) begin
      tick();
      chk($sformatf("run.pc%0d", k), bus.prog_ctr, k);
    end
    chk("run.not_done_at_127", bus.done, 0);
    tick();
    chk("run.end_done", bus.done, 1);
    chk("run.end_pc", bus.prog_ctr, 128);
    chk("run.end_cnt", bus.cycle_cnt, 128);
    chk("run.end_busy", bus.busy, 0);
    tick();
    chk("run.done_held", bus.done, 1);
`endif

    // stall at PC=10 for three cycles
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_idle();
    for (int k = 0; k < 10; k++) tick();
    chk("stall.pre_pc", bus.prog_ctr, 10);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.pc", bus.prog_ctr, 10);
      chk("stall.cnt", bus.cycle_cnt, 10);
      chk("stall.run_en", bus.run_en, 0);
      chk("stall.busy", bus.busy, 1);
    end
    drive_idle();
    tick();
    chk("stall.resume_pc", bus.prog_ctr, 11);
    chk("stall.resume_cnt", bus.cycle_cnt, 11);

    // halt at PC=9, restart, then reset mid-run
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_idle();
    for (int k = 0; k < 9; k++) tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive_idle();
    chk("halt.done", bus.done, 1);
    chk("halt.pc", bus.prog_ctr, 9);
    chk("halt.busy", bus.busy, 0);
    chk("halt.cnt", bus.cycle_cnt, 10);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_idle();
    chk("restart.pc", bus.prog_ctr, 0);
    chk("restart.done", bus.done, 0);
    chk("restart.busy", bus.busy, 1);
    tick(); tick(); tick();
    chk("restart.pc3", bus.prog_ctr, 3);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst.pc", bus.prog_ctr, 0);
    chk("midrst.done", bus.done, 0);
    chk("midrst.busy", bus.busy, 0);
    chk("midrst.run_en", bus.run_en, 0);
    chk("midrst.cnt", bus.cycle_cnt, 0);
    chk("midrst.timeout", bus.timeout, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("midrst.no_done", bus.done, 0);

    // branch loop on lut[0]=0
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    for (int k = 0; k < 100 && bus.busy; k++) tick();
    chk("wdog.done", bus.done, 1);
    chk("wdog.timeout", bus.timeout, 1);
    chk("wdog.cnt", bus.cycle_cnt, WDOG);
    chk("wdog.pc", bus.prog_ctr, 0);
`else
    for (int k = 0; k < 60; k++) tick();
    chk("loop.busy", bus.busy, 1);
    chk("loop.timeout", bus.timeout, 0);
    chk("loop.cnt", bus.cycle_cnt, 60);
    chk("loop.pc", bus.prog_ctr, 0);
`endif

    // random stimulus against the model
    do_reset();
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, a, int'($urandom_range(0, 255)));
      tick();
    end
    check_model("fill");
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 16) == 0,
            int'($urandom % 32), ($urandom % 8) == 0, int'($urandom % 256),
            ($urandom % 40) == 0, ($urandom % 4) == 0, int'($urandom % 32),
            int'($urandom_range(0, 255)));
      tick();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
